// File: rtl/store_pkg.sv
// store_pkg: width encodings, lane positions and FSM states for the store merge path
package store_pkg;
  localparam logic [2:0] WIDTH_WORD = 3'b001;
  localparam logic [2:0] WIDTH_HALF = 3'b010;
  localparam logic [2:0] WIDTH_BYTE = 3'b100;
  localparam logic [1:0] POS_0 = 2'd0;
  localparam logic [1:0] POS_1 = 2'd1;
  localparam logic [1:0] POS_2 = 2'd2;
  localparam logic [1:0] POS_3 = 2'd3;
  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, ERR} state_t;
endpackage

// File: rtl/store_lane_merge.sv
// store_lane_merge: replaces the lanes selected by width/pos in old_word with new_data
module store_lane_merge
  import store_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  logic [2:0]  width,
  input  logic [1:0]  pos,
  output logic [31:0] merged
);
  logic [31:0] mask, lanes;
  assign mask = width == WIDTH_WORD ? 32'hFFFF_FFFF :
                width == WIDTH_HALF ? (pos == POS_2 ? 32'hFFFF_0000 : 32'h0000_FFFF) :
                width == WIDTH_BYTE ? 32'h0000_00FF << {pos, 3'b000} : 32'h0;
  assign lanes = width == WIDTH_HALF ? {2{new_data[15:0]}} :
                 width == WIDTH_BYTE ? {4{new_data[7:0]}} : new_data;
  assign merged = (old_word & ~mask) | (lanes & mask);
endmodule

// File: rtl/store_merge_unit.sv
// store_merge_unit: word/half/byte stores into a word-only DMEM via read-modify-write
module store_merge_unit
  import store_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_width,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [31:0]       mem_rdata,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic              misalign_err,
  output logic              busy
);
  state_t state;
  logic [2:0] width_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0] data_q, merged_q, merged;
  logic accept, word_ok, sub_ok;
  assign req_ready = rst_n && state == IDLE;
  assign accept = req_valid && req_ready;
  assign word_ok = req_width == WIDTH_WORD && req_addr[1:0] == POS_0;
  assign sub_ok = (req_width == WIDTH_HALF && !req_addr[0]) || req_width == WIDTH_BYTE;
  assign busy = rst_n && state != IDLE;
  assign mem_rd = rst_n && state == READ;
  assign mem_wr = rst_n && state == WRITE;
  assign done = mem_wr;
  assign misalign_err = rst_n && state == ERR;
  assign mem_addr = busy ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wdata = mem_wr ? merged_q : '0;
  store_lane_merge u_merge (
    .old_word(mem_rdata),
    .new_data(data_q),
    .width(width_q),
    .pos(addr_q[1:0]),
    .merged(merged)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      width_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      merged_q <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          width_q <= req_width;
          addr_q <= req_addr;
          data_q <= req_data;
          merged_q <= req_data;
          state <= word_ok ? WRITE : sub_ok ? READ : ERR;
        end
        READ: state <= MERGE;
        MERGE: begin
          merged_q <= merged;
          state <= WRITE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_store_merge_unit.sv
// tb_store_merge_unit: random and directed stores checked against a byte-array memory model
module tb_store_merge_unit;
  logic clk = 0, rst_n = 0, req_valid = 0, req_ready;
  logic [2:0] req_width = '0;
  logic [31:0] req_addr = '0, req_data = '0, mem_addr, mem_rdata, mem_wdata;
  logic mem_rd, mem_wr, done, misalign_err, busy;
  logic pl_en = 0;
  logic [3:0] pl_idx = '0;
  logic [31:0] pl_data = '0, last_wdata;
  logic [31:0] dmem [16];
  logic [7:0] refm [64];
  int tests = 0, fails = 0, wr_count = 0;
  store_merge_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_width(req_width), .req_addr(req_addr), .req_data(req_data),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .done(done), .misalign_err(misalign_err), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= dmem[mem_addr[5:2]];
    if (mem_wr) dmem[mem_addr[5:2]] <= mem_wdata;
    if (mem_wr) wr_count <= wr_count + 1;
    if (pl_en) dmem[pl_idx] <= pl_data;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_ready"}, req_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rd"}, mem_rd, 0);
    check({tag, "_wr"}, mem_wr, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, misalign_err, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
  endtask
  function automatic int base(input logic [31:0] a);
    return int'(a[5:2]) * 4;
  endfunction
  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int b = base(a);
    return {refm[b+3], refm[b+2], refm[b+1], refm[b]};
  endfunction
  function automatic int kind(input logic [2:0] w, input logic [31:0] a);
    if (w == 3'b001) return a[1:0] == 2'b00 ? 0 : 2;
    if (w == 3'b010) return a[0] ? 2 : 1;
    if (w == 3'b100) return 1;
    return 2;
  endfunction
  function automatic void apply_ref(input logic [2:0] w, input logic [31:0] a, input logic [31:0] d);
    int b = base(a);
    if (w == 3'b001) for (int k = 0; k < 4; k++) refm[b+k] = d[8*k +: 8];
    else if (w == 3'b010) begin
      refm[b + 2*int'(a[1])] = d[7:0];
      refm[b + 2*int'(a[1]) + 1] = d[15:8];
    end else refm[b + int'(a[1:0])] = d[7:0];
  endfunction
  task automatic preload(input int i, input logic [31:0] w);
    @(negedge clk);
    pl_en = 1; pl_idx = 4'(i); pl_data = w;
    for (int k = 0; k < 4; k++) refm[4*i+k] = w[8*k +: 8];
    @(posedge clk);
    #1 pl_en = 0;
  endtask
  task automatic do_store(input logic [2:0] w, input logic [31:0] a, input logic [31:0] d);
    int k = kind(w, a);
    logic [31:0] wa = {a[31:2], 2'b00};
    @(negedge clk);
    req_valid = 1; req_width = w; req_addr = a; req_data = d;
    check("ready_idle", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 0; req_width = 3'($urandom); req_addr = $urandom; req_data = $urandom;
    @(negedge clk);
    check("busy_n1", busy, 1);
    if (k == 2) begin
      check("err_n1", misalign_err, 1);
      check("err_rd", mem_rd, 0);
      check("err_wr", mem_wr, 0);
    end else if (k == 0) begin
      apply_ref(w, a, d);
      check("word_wr", mem_wr, 1);
      check("word_rd", mem_rd, 0);
      check("word_done", done, 1);
      check("word_addr", mem_addr, wa);
      check("word_wdata", mem_wdata, ref_word(a));
      last_wdata = mem_wdata;
    end else begin
      check("sub_rd", mem_rd, 1);
      check("sub_rd_wr", mem_wr, 0);
      check("sub_rd_addr", mem_addr, wa);
      check("sub_ready", req_ready, 0);
      @(negedge clk);
      check("merge_busy", busy, 1);
      check("merge_rd", mem_rd, 0);
      check("merge_wr", mem_wr, 0);
      apply_ref(w, a, d);
      @(negedge clk);
      check("sub_wr", mem_wr, 1);
      check("sub_wr_rd", mem_rd, 0);
      check("sub_done", done, 1);
      check("sub_addr", mem_addr, wa);
      check("sub_wdata", mem_wdata, ref_word(a));
      last_wdata = mem_wdata;
    end
    @(negedge clk);
    check("ready_after", req_ready, 1);
    check("idle_busy", busy, 0);
  endtask
  initial begin
    int wc;
    for (int i = 0; i < 16; i++) preload(i, $urandom);
    @(negedge clk);
    check_zero("rst");
    rst_n = 1;
    @(negedge clk);
    check("ready_post_rst", req_ready, 1);
    preload(0, 32'h1122_3344);
    do_store(3'b100, 32'h203, 32'h0000_00AB);
    check("spec_byte", last_wdata, 32'hAB22_3344);
    preload(0, 32'h1122_3344);
    do_store(3'b010, 32'h202, 32'h0000_CAFE);
    check("spec_half_hi", last_wdata, 32'hCAFE_3344);
    preload(0, 32'h1122_3344);
    do_store(3'b010, 32'h200, 32'h0000_CAFE);
    check("spec_half_lo", last_wdata, 32'h1122_CAFE);
    do_store(3'b001, 32'h100, 32'hDEAD_BEEF);
    check("spec_word", last_wdata, 32'hDEAD_BEEF);
    wc = wr_count;
    do_store(3'b010, 32'h201, 32'h1234_5678);
    do_store(3'b011, 32'h200, 32'h1234_5678);
    do_store(3'b000, 32'h200, 32'h1234_5678);
    do_store(3'b001, 32'h202, 32'h1234_5678);
    check("err_no_write", 32'(wr_count), 32'(wc));
    preload(0, 32'h1122_3344);
    @(negedge clk);
    req_valid = 1; req_width = 3'b100; req_addr = 32'h203; req_data = 32'hAB;
    check("b2b_ready0", req_ready, 1);
    @(posedge clk);
    #1 req_width = 3'b001; req_addr = 32'h104; req_data = 32'h1357_9BDF;
    apply_ref(3'b100, 32'h203, 32'hAB);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("b2b_ready_busy", req_ready, 0);
    end
    check("b2b_wr1", mem_wr, 1);
    check("b2b_wdata1", mem_wdata, 32'hAB22_3344);
    @(negedge clk);
    check("b2b_ready_n4", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 0;
    apply_ref(3'b001, 32'h104, 32'h1357_9BDF);
    @(negedge clk);
    check("b2b_wr2", mem_wr, 1);
    check("b2b_addr2", mem_addr, 32'h104);
    check("b2b_wdata2", mem_wdata, 32'h1357_9BDF);
    @(negedge clk);
    check("b2b_ready_end", req_ready, 1);
    @(negedge clk);
    req_valid = 1; req_width = 3'b100; req_addr = 32'h201; req_data = 32'h5A;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    check("rstmid_rd", mem_rd, 1);
    @(posedge clk);
    #1 rst_n = 0;
    wc = wr_count;
    @(negedge clk);
    check_zero("rstmid_a");
    @(negedge clk);
    check_zero("rstmid_b");
    rst_n = 1;
    @(negedge clk);
    check("rstmid_ready", req_ready, 1);
    check("rstmid_no_wr", 32'(wr_count), 32'(wc));
    do_store(3'b001, 32'h108, 32'hA5A5_0F0F);
    do_store(3'b100, 32'h200, 32'h77);
    for (int i = 0; i < 60; i++) begin
      logic [2:0] w;
      int r = $urandom_range(0, 9);
      w = r < 3 ? 3'b001 : r < 6 ? 3'b010 : r < 9 ? 3'b100 : 3'($urandom);
      do_store(w, $urandom, $urandom);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
